// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Brief    : Modulo-MODULUS up/down counter with clear, clamped load, terminal
//            count, wrap pulse and sticky overflow flag. Defining the macro
//            UPDOWN_CNT_SATURATE_EN makes the count saturate instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

`ifdef UPDOWN_CNT_SATURATE_EN
  localparam bit c_saturate = 1'b1;
`else
  localparam bit c_saturate = 1'b0;
`endif

  localparam logic [WIDTH-1:0] c_max_val = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_min, boundary;

  always_comb begin
    at_max   = (count_q == c_max_val);
    at_min   = (count_q == '0);
    boundary = en & ~clr & ~load & ((up & at_max) | (~up & at_min));

    count_d  = count_q;
    ovf_d    = ovf_q | boundary;
    // The pulse is suppressed in saturating builds; the event still sets the flag.
    wrap_d   = boundary & ~c_saturate;

    if (clr) begin
      count_d = c_rst_val;
      ovf_d   = 1'b0;
      wrap_d  = 1'b0;
    end else if (load) begin
      count_d = (load_val > c_max_val) ? c_max_val : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) count_d = c_saturate ? c_max_val : '0;
        else        count_d = count_q + c_one;
      end else begin
        if (at_min) count_d = c_saturate ? '0 : c_max_val;
        else        count_d = count_q - c_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= c_rst_val;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q          = count_q;
  assign tc         = boundary;
  assign wrap       = wrap_q;
  assign ovf_sticky = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_param_updown_counter
// Brief    : Randomized scoreboard bench for param_updown_counter against an
//            arithmetic reference model; honours UPDOWN_CNT_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;
  localparam int RV    = 0;
`ifdef UPDOWN_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, clr, load, en, up;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc, wrap, ovf_sticky;

  logic             rst2_n;
  logic [1:0]       q2;
  logic             tc2, wrap2, ovf2;

  param_updown_counter #(.WIDTH(WIDTH), .MODULUS(MOD), .RESET_VAL(RV)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q), .tc(tc), .wrap(wrap), .ovf_sticky(ovf_sticky)
  );

  param_updown_counter #(.WIDTH(2), .MODULUS(2), .RESET_VAL(0)) u_dut_m2 (
    .clk(clk), .rst_n(rst2_n), .clr(1'b0), .load(1'b0), .load_val(2'd0),
    .en(1'b1), .up(1'b1), .q(q2), .tc(tc2), .wrap(wrap2), .ovf_sticky(ovf2)
  );

  typedef struct {
    int q;
    bit wrap;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   m_q   = RV;
  bit   m_ovf = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check tc, advance the model, queue the result.
  task automatic cycle(bit c, bit l, int lv, bit e, bit u);
    bit   bnd;
    exp_t x;
    @(negedge clk);
    clr = c; load = l; load_val = lv[WIDTH-1:0]; en = e; up = u;
    #1;
    bnd = e && !c && !l && ((u && m_q == MOD-1) || (!u && m_q == 0));
    check("tc", int'(tc), int'(bnd));
    if (c) begin
      m_q = RV; m_ovf = 1'b0;
    end else if (l) begin
      m_q = (lv >= MOD) ? MOD-1 : lv;
    end else if (e) begin
      if (u) m_q = SAT ? ((m_q + 1 > MOD-1) ? MOD-1 : m_q + 1) : (m_q + 1) % MOD;
      else   m_q = SAT ? ((m_q - 1 < 0) ? 0 : m_q - 1) : (m_q + MOD - 1) % MOD;
    end
    if (bnd) m_ovf = 1'b1;
    x.q = m_q; x.wrap = bnd && !SAT && !c; x.ovf = m_ovf;
    sb.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0;
  endtask

  // Reset asserted between edges must act before the next clock edge.
  task automatic async_reset();
    @(negedge clk);
    clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_q", int'(q), RV);
    check("rst_wrap", int'(wrap), 0);
    check("rst_ovf", int'(ovf_sticky), 0);
    check("rst_tc", int'(tc), (RV == 0) ? 1 : 0);
    en = 1'b0;
    m_q = RV; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q", int'(q), e.q);
      check("wrap", int'(wrap), int'(e.wrap));
      check("ovf_sticky", int'(ovf_sticky), int'(e.ovf));
    end
  end

  // MODULUS=2 instance counting up continuously from reset.
  initial begin
    int m2 = 0;
    bit b2;
    rst2_n = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (16) begin
      @(posedge clk);
      b2 = (m2 == 1);
      m2 = b2 ? (SAT ? 1 : 0) : m2 + 1;
      #1;
      check("m2_q", int'(q2), m2);
      check("m2_wrap", int'(wrap2), int'(b2 && !SAT));
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b0;
    #12;
    check("init_q", int'(q), RV);
    check("init_wrap", int'(wrap), 0);
    check("init_ovf", int'(ovf_sticky), 0);
    check("init_tc", int'(tc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (12) cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle();
    #2;
    check("up12_q", int'(q), SAT ? 9 : 2);
    check("up12_ovf", int'(ovf_sticky), 1);

    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

    cycle(1'b0, 1'b1, 13, 1'b0, 1'b0);
    idle();
    #2;
    check("clamp_q", int'(q), 9);
    cycle(1'b0, 1'b1, 5, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 7, 1'b1, 1'b1);
    idle();
    #2;
    check("clr_wins_q", int'(q), RV);
    check("clr_wins_ovf", int'(ovf_sticky), 0);

    repeat (6) cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 16) == 0, ($urandom % 8) == 0, int'($urandom % 16),
            ($urandom % 4) != 0, ($urandom % 2) == 1);
      if (i % 100 == 99) async_reset();
    end

    idle();
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
